// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter for the combinational instruction ROM: IF port has priority,
// the debug port is forced ahead after MAX_WAIT refused cycles. One-cycle read latency.
module inst_rom_arbiter #(
    parameter int ROM_AW   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORM, FORCE} state_t;

    state_t          state;
    logic [WCW-1:0]  wait_cnt;
    logic [31:0]     sel_addr_p0;
    logic            legal_p0;
    logic            i_vld_p1;
    logic            i_err_p1;
    logic            d_vld_p1;
    logic            d_err_p1;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:ROM_AW+2] == '0);
    endfunction

    // Stage p0: arbitration and ROM drive
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (state == FORCE) begin
                // A dropped debug request leaves the slot to IF.
                d_gnt = d_req;
                i_gnt = i_req && !d_req;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req && !i_req;
            end
        end
        sel_addr_p0 = d_gnt ? d_addr : i_addr;
        legal_p0    = addr_legal(sel_addr_p0);
        rom_ce      = (i_gnt || d_gnt) && legal_p0;
        rom_addr    = rom_ce ? sel_addr_p0 : 32'h0;
    end

    // Stage p1: registered responses and starvation FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= NORM;
            wait_cnt <= '0;
            i_vld_p1 <= 1'b0;
            i_err_p1 <= 1'b0;
            d_vld_p1 <= 1'b0;
            d_err_p1 <= 1'b0;
            i_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            i_vld_p1 <= i_gnt;
            i_err_p1 <= i_gnt && !legal_p0;
            d_vld_p1 <= d_gnt;
            d_err_p1 <= d_gnt && !legal_p0;
            if (i_gnt) begin
                i_rdata <= legal_p0 ? rom_inst : 32'h0;
            end
            if (d_gnt) begin
                d_rdata <= legal_p0 ? rom_inst : 32'h0;
            end

            case (state)
                NORM: begin
                    if (d_gnt) begin
                        wait_cnt <= '0;
                    end else if (d_req) begin
                        if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                            state    <= FORCE;
                            wait_cnt <= WCW'(MAX_WAIT);
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                FORCE: begin
                    state    <= NORM;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= NORM;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Responses never appear while reset is held; a flushed IF response is squashed.
    assign i_rvalid = i_vld_p1 && rst && !i_flush;
    assign i_err    = i_err_p1 && rst && !i_flush;
    assign d_rvalid = d_vld_p1 && rst;
    assign d_err    = d_err_p1 && rst;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed table-driven bench for inst_rom_arbiter with a behavioural ROM.
module tb_inst_rom_arbiter;

    localparam logic [31:0] R0 = 32'h3408_0001;
    localparam logic [31:0] R1 = 32'h3409_0001;
    localparam logic [31:0] R2 = 32'h0109_5021;
    localparam logic [31:0] R4 = 32'hAC0A_0010;
    localparam logic [31:0] R5 = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, d_req;
    logic [31:0] i_addr, d_addr;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, rom_ce;
    logic [31:0] i_rdata, d_rdata, rom_addr, rom_inst;
    logic [31:0] rom [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst, i_req;
        logic [31:0] i_addr;
        logic        i_flush, d_req;
        logic [31:0] d_addr;
        logic        ig, dg, ce;
        logic [31:0] ra;
        logic        irv, ierr;
        logic [31:0] ird;
        logic        drv, derr;
        logic [31:0] drd;
        logic        rd_dc;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    assign rom_inst = rom_ce ? rom[rom_addr[11:2]] : 32'hDEAD_BEEF;

    inst_rom_arbiter #(.ROM_AW(10), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(
        input logic r, input logic ir, input logic [31:0] ia, input logic fl,
        input logic dr, input logic [31:0] da,
        input logic ig, input logic dg, input logic ce, input logic [31:0] ra,
        input logic irv, input logic ierr, input logic [31:0] ird,
        input logic drv, input logic derr, input logic [31:0] drd, input logic dc);
        vec_t v;
        v.rst = r;    v.i_req = ir;  v.i_addr = ia;  v.i_flush = fl;
        v.d_req = dr; v.d_addr = da;
        v.ig = ig;    v.dg = dg;     v.ce = ce;      v.ra = ra;
        v.irv = irv;  v.ierr = ierr; v.ird = ird;
        v.drv = drv;  v.derr = derr; v.drd = drd;    v.rd_dc = dc;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic fl, input logic dr, input logic [31:0] da);
        rst = r; i_req = ir; i_addr = ia; i_flush = fl; d_req = dr; d_addr = da;
    endtask

    initial begin
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 1024; k++) rom[k] = 32'hA000_0000 | k;
        rom[0] = R0; rom[1] = R1; rom[2] = R2; rom[4] = R4; rom[5] = R5;

        //  rst ir ia       fl dr da      ig dg ce ra      irv ie ird   drv de drd  dc
        add(0, 1, 0,       0, 1, 0,      0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0);
        add(0, 1, 0,       0, 1, 0,      0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0);
        add(1, 1, 0,       0, 0, 0,      1, 0, 1, 0,      0, 0, 0,     0, 0, 0,  0);
        add(1, 1, 4,       0, 0, 0,      1, 0, 1, 4,      1, 0, R0,    0, 0, 0,  0);
        add(1, 1, 8,       0, 0, 0,      1, 0, 1, 8,      1, 0, R1,    0, 0, 0,  0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      1, 0, R2,    0, 0, 0,  0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      0, 0, R2,    0, 0, 0,  0);
        add(1, 0, 0,       0, 1, 2,      0, 1, 0, 0,      0, 0, R2,    0, 0, 0,  0);
        add(1, 1, 'h1000,  0, 0, 0,      1, 0, 0, 0,      0, 0, R2,    1, 1, 0,  0);
        add(1, 1, 'h10,    0, 0, 0,      1, 0, 1, 'h10,   1, 1, 0,     0, 0, 0,  0);
        add(1, 0, 0,       0, 1, 4,      0, 1, 1, 4,      1, 0, R4,    0, 0, 0,  0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      0, 0, R4,    1, 0, R1, 0);
        add(1, 1, 0,       0, 1, 'h10,   1, 0, 1, 0,      0, 0, R4,    0, 0, R1, 0);
        for (int k = 0; k < 3; k++)
            add(1, 1, 0,   0, 1, 'h10,   1, 0, 1, 0,      1, 0, R0,    0, 0, R1, 0);
        add(1, 1, 0,       0, 1, 'h10,   0, 1, 1, 'h10,   1, 0, R0,    0, 0, R1, 0);
        add(1, 1, 0,       0, 0, 0,      1, 0, 1, 0,      0, 0, R0,    1, 0, R4, 0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      1, 0, R0,    0, 0, R4, 0);
        add(1, 1, 'h14,    0, 0, 0,      1, 0, 1, 'h14,   0, 0, R0,    0, 0, R4, 0);
        add(1, 1, 0,       1, 0, 0,      1, 0, 1, 0,      0, 0, R0,    0, 0, R4, 1);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      1, 0, R0,    0, 0, R4, 0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      0, 0, R0,    0, 0, R4, 0);
        add(1, 1, 0,       0, 1, 'h10,   1, 0, 1, 0,      0, 0, R0,    0, 0, R4, 0);
        for (int k = 0; k < 3; k++)
            add(1, 1, 0,   0, 1, 'h10,   1, 0, 1, 0,      1, 0, R0,    0, 0, R4, 0);
        // Forced slot with the debug request withdrawn goes to IF.
        add(1, 1, 0,       0, 0, 0,      1, 0, 1, 0,      1, 0, R0,    0, 0, R4, 0);
        add(1, 1, 4,       0, 1, 'h10,   1, 0, 1, 4,      1, 0, R0,    0, 0, R4, 0);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      1, 0, R1,    0, 0, R4, 0);
        add(1, 0, 0,       0, 1, 8,      0, 1, 1, 8,      0, 0, R1,    0, 0, R4, 0);
        add(0, 0, 0,       0, 0, 0,      0, 0, 0, 0,      0, 0, R1,    0, 0, R2, 1);
        add(1, 0, 0,       0, 0, 0,      0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0);

        @(posedge clk); #1;
        for (int r = 0; r < vq.size(); r++) begin
            vec_t v;
            v = vq[r];
            drive(v.rst, v.i_req, v.i_addr, v.i_flush, v.d_req, v.d_addr);
            #3;
            chk($sformatf("row%0d.i_gnt", r), {31'b0, i_gnt}, {31'b0, v.ig});
            chk($sformatf("row%0d.d_gnt", r), {31'b0, d_gnt}, {31'b0, v.dg});
            chk($sformatf("row%0d.rom_ce", r), {31'b0, rom_ce}, {31'b0, v.ce});
            chk($sformatf("row%0d.rom_addr", r), rom_addr, v.ra);
            chk($sformatf("row%0d.i_rvalid", r), {31'b0, i_rvalid}, {31'b0, v.irv});
            chk($sformatf("row%0d.i_err", r), {31'b0, i_err}, {31'b0, v.ierr});
            chk($sformatf("row%0d.d_rvalid", r), {31'b0, d_rvalid}, {31'b0, v.drv});
            chk($sformatf("row%0d.d_err", r), {31'b0, d_err}, {31'b0, v.derr});
            if (!v.rd_dc) begin
                chk($sformatf("row%0d.i_rdata", r), i_rdata, v.ird);
                chk($sformatf("row%0d.d_rdata", r), d_rdata, v.drd);
            end
            @(posedge clk); #1;
        end

        // Reset in the middle of a starvation build-up clears the wait count.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
            #3;
            chk($sformatf("pre%0d.d_gnt", k), {31'b0, d_gnt}, 32'h0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
        #3;
        chk("rstcyc.i_gnt", {31'b0, i_gnt}, 32'h0);
        chk("rstcyc.d_gnt", {31'b0, d_gnt}, 32'h0);
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
            #3;
            chk($sformatf("post%0d.i_gnt", k), {31'b0, i_gnt}, (k == 5) ? 32'h0 : 32'h1);
            chk($sformatf("post%0d.d_gnt", k), {31'b0, d_gnt}, (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("post%0d.rom_addr", k), rom_addr, (k == 5) ? 32'h10 : 32'h0);
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #3;
        chk("post.d_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("post.d_rdata", d_rdata, R4);
        chk("post.i_rvalid", {31'b0, i_rvalid}, 32'h0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
